// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver (LSB first) with a small registered-output FIFO.
//
// rxd is brought into the clk domain through a two-flop synchroniser. A
// five-state machine stepped by the oversampling tick clk_en finds the start
// bit, checks it at mid-bit and samples eight data bits and the stop bit at
// their centres. Good bytes go into a circular FIFO whose head is
// presented on rx_data / rx_valid from flops (first-word-fall-through).
// Framing and overrun errors are sticky until err_clr.
//
// Parameters
//   OVS      oversampling ticks per bit (even, 4..64)
//   FIFO_AW  FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   clk_en    in   oversample tick, one clk wide, OVS x bit rate
//   rxd       in   asynchronous serial input, idle high
//   rd        in   pop strobe for the FIFO head (ignored when empty)
//   err_clr   in   clears ferr and overrun (a same-cycle set wins)
//   rx_data   out  FIFO head byte, meaningful while rx_valid=1
//   rx_valid  out  FIFO not empty
//   ferr      out  sticky framing error
//   overrun   out  sticky overrun (byte dropped, FIFO full)
//   busy      out  receiver state machine not idle
module uart_rx #(
  parameter int OVS     = 16,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       rxd,
  input  logic       rd,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ferr,
  output logic       overrun,
  output logic       busy
);

  localparam int TW    = $clog2(OVS);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  localparam logic [TW-1:0]      HALF_M1  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0]      FULL_M1  = TW'(OVS - 1);
  localparam logic [TW-1:0]      TICK_ONE = TW'(1);
  localparam logic [CW-1:0]      DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_e;

  // Synchroniser
  logic meta_q, meta_d;
  logic rxs_q, rxs_d;

  // Receiver state
  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          push;
  logic          ferr_set;

  // FIFO
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               ovr_set;

  // Outputs and flags
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ferr_q, ferr_d;
  logic       overrun_q, overrun_d;

  // Stage 0: two-flop synchroniser, free running on clk
  always_comb begin
    meta_d = rxd;
    rxs_d  = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= meta_d;
      rxs_q  <= rxs_d;
    end
  end

  // Stage 1: bit-timing state machine, advances only on clk_en
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          // This tick is t0; the start bit centre is OVS/2 ticks away.
          if (!rxs_q) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == HALF_M1) begin
            if (rxs_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        S_DATA: begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            shreg_d = {rxs_q, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        S_STOP: begin
          // Returning to IDLE on the sample tick (not the end of the stop
          // bit) leaves half a bit of slack for a fast sender.
          if (tick_q == FULL_M1) begin
            tick_d = '0;
            if (rxs_q) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_set = 1'b1;
              state_d  = S_BRK;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        S_BRK: begin
          // A held-low line raises ferr once, then waits for idle here.
          if (rxs_q) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  // Stage 2: FIFO and registered head
  always_comb begin
    pop     = rd && (count_q != '0);
    full    = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot the push needs.
    push_ok = push && (!full || pop);
    ovr_set = push && full && !pop;

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shreg_q;
    end

    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // The head is taken from next-cycle contents so a byte pushed into an
    // empty FIFO is visible right after the push edge.
    rx_valid_d = (count_d != '0);
    rx_data_d  = rx_valid_d ? mem_d[rd_ptr_d] : rx_data_q;

    ferr_d = err_clr ? 1'b0 : ferr_q;
    if (ferr_set) begin
      ferr_d = 1'b1;
    end
    overrun_d = err_clr ? 1'b0 : overrun_q;
    if (ovr_set) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign ferr     = ferr_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - self-checking bench for uart_rx (OVS=16, FIFO_AW=2).
// Ticks arrive every 4 clk, so one bit is 64 clk. Frames start with the
// falling edge placed so that the first tick seeing the synchronised low is
// exactly 3 clk later; the stop sample edge then lands 611 clk after the
// frame starts.
module tb_uart_rx;

  localparam int OVS     = 16;
  localparam int FIFO_AW = 2;
  localparam int BITC    = 64;
  localparam int C_PUSH  = 610;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       rxd;
  logic       rd;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ferr;
  logic       overrun;
  logic       busy;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         rises = 0;
  logic       vld_prev = 1'b0;
  logic [7:0] exp_q[$];

  logic vld_before, vld_after, busy_mid, busy_before, busy_after, ferr_after;

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    bit         exp_push;
    bit         exp_busy_after;
    bit         exp_ferr;
    bit         clr_after;
  } vec_t;

  vec_t tbl[5];

  uart_rx #(.OVS(OVS), .FIFO_AW(FIFO_AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .rxd      (rxd),
    .rd       (rd),
    .err_clr  (err_clr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ferr     (ferr),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Tick generator: cyc counts posedges, clk_en high for the cycle after
  // every posedge with cyc % 4 == 0.
  initial begin
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc    = cyc + 1;
      clk_en = (cyc % 4 == 0);
    end
  end

  // Count rising edges of rx_valid.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rx_valid && !vld_prev) rises = rises + 1;
      vld_prev = rx_valid;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Drives one frame. stop_low>0 holds the line low that many bit times from
  // the stop bit on. rd_at_push raises rd exactly in the push cycle.
  // abort_c>=0 asserts reset at that cycle of the frame and abandons it.
  task automatic send_frame(input logic [7:0] d, input int stop_low, input bit exp_push,
                            input bit rd_at_push, input int abort_c);
    int total;
    total = BITC * 10 + BITC * stop_low;
    while (cyc % 4 != 2) @(negedge clk);
    if (exp_push) exp_q.push_back(d);
    for (int c = 0; c < total; c++) begin
      if (c == abort_c) begin
        reset = 1'b1;
        #1;
        chk("rst_async_valid", rx_valid, 0);
        chk("rst_async_data", rx_data, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_ferr", ferr, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rxd   = 1'b1;
        reset = 1'b0;
        break;
      end
      if (c == BITC * 5) busy_mid = busy;
      if (c == C_PUSH) begin
        vld_before  = rx_valid;
        busy_before = busy;
        if (rd_at_push) begin
          if (exp_q.size() > 0) chk("head_at_push", rx_data, exp_q.pop_front());
          rd = 1'b1;
        end
      end
      if (c == C_PUSH + 1) begin
        vld_after  = rx_valid;
        busy_after = busy;
        ferr_after = ferr;
        rd         = 1'b0;
      end
      if (c < BITC) rxd = 1'b0;
      else if (c < BITC * 9) rxd = d[(c / BITC) - 1];
      else if (c < BITC * 9 + BITC * stop_low) rxd = 1'b0;
      else rxd = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic pop_chk(input string name);
    logic [7:0] e;
    chk({name, "_valid"}, rx_valid, 1);
    if (exp_q.size() == 0) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL %s_sb: pop with no expected byte, got 0x%0h", name, rx_data);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_data"}, rx_data, e);
    end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    int r0;
    tbl[0] = '{8'hA5, 0,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 0,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 0,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h55, 20, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h81, 0,  1'b1, 1'b0, 1'b1, 1'b1};

    reset   = 1'b1;
    rxd     = 1'b1;
    rd      = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", rx_data, 0);
    chk("reset_valid", rx_valid, 0);
    chk("reset_ferr", ferr, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Table-driven single frames
    for (int i = 0; i < 5; i++) begin
      r0 = rises;
      send_frame(tbl[i].data, tbl[i].stop_low, tbl[i].exp_push, 1'b0, -1);
      chk($sformatf("r%0d_vld_before", i), vld_before, 0);
      chk($sformatf("r%0d_vld_after", i), vld_after, tbl[i].exp_push);
      chk($sformatf("r%0d_busy_mid", i), busy_mid, 1);
      chk($sformatf("r%0d_busy_before", i), busy_before, 1);
      chk($sformatf("r%0d_busy_after", i), busy_after, tbl[i].exp_busy_after);
      chk($sformatf("r%0d_ferr_after", i), ferr_after, tbl[i].exp_ferr);
      chk($sformatf("r%0d_rises", i), rises - r0, tbl[i].exp_push);
      if (tbl[i].exp_push) pop_chk($sformatf("r%0d_pop", i));
      chk($sformatf("r%0d_empty", i), rx_valid, 0);
      chk($sformatf("r%0d_ferr", i), ferr, tbl[i].exp_ferr);
      chk($sformatf("r%0d_overrun", i), overrun, 0);
      if (tbl[i].clr_after) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk($sformatf("r%0d_ferr_clr", i), ferr, 0);
      end
    end

    // rd on an empty FIFO is ignored
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    chk("rd_empty_valid", rx_valid, 0);

    // Start-bit glitch: 5 ticks low, rejected at t0+8
    while (cyc % 4 != 2) @(negedge clk);
    for (int c = 0; c < 48; c++) begin
      if (c == 2)  chk("glitch_busy_c2", busy, 0);
      if (c == 3)  chk("glitch_busy_c3", busy, 1);
      if (c == 34) chk("glitch_busy_c34", busy, 1);
      if (c == 35) chk("glitch_busy_c35", busy, 0);
      rxd = (c < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", ferr, 0);
    send_frame(8'h3C, 0, 1'b1, 1'b0, -1);
    pop_chk("glitch_3c");
    chk("glitch_empty", rx_valid, 0);

    // Overrun: five frames into a four-deep FIFO
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 0, (b < 5), 1'b0, -1);
    end
    chk("ovr_set", overrun, 1);
    chk("ovr_ferr", ferr, 0);
    for (int j = 0; j < 4; j++) pop_chk($sformatf("ovr_pop%0d", j));
    chk("ovr_empty", rx_valid, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Full FIFO, pop on the exact push cycle of 0xEE
    for (int b = 0; b < 4; b++) begin
      send_frame(8'h10 + 8'(b), 0, 1'b1, 1'b0, -1);
    end
    chk("full_ovr0", overrun, 0);
    send_frame(8'hEE, 0, 1'b1, 1'b1, -1);
    chk("simul_vld", vld_after, 1);
    chk("simul_ovr", overrun, 0);
    for (int j = 0; j < 4; j++) pop_chk($sformatf("simul_pop%0d", j));
    chk("simul_empty", rx_valid, 0);

    // Reset during bit 3 of 0x96 with one byte already queued
    send_frame(8'h77, 0, 1'b1, 1'b0, -1);
    send_frame(8'h96, 0, 1'b0, 1'b0, BITC * 4 + 30);
    repeat (128) @(negedge clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_valid", rx_valid, 0);
    chk("postrst_ferr", ferr, 0);
    chk("postrst_ovr", overrun, 0);
    send_frame(8'h6A, 0, 1'b1, 1'b0, -1);
    chk("rst6a_ferr", ferr, 0);
    chk("rst6a_ovr", overrun, 0);
    pop_chk("rst6a");
    chk("rst6a_empty", rx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
